// File: rtl/sdram_arbit_pkg.sv
// Shared SDRAM definitions: command encodings {cs_n,ras_n,cas_n,we_n} and arbiter states,
// reused by the init, refresh, write, read and arbiter blocks.
package sdram_arbit_pkg;

  localparam int unsigned CMD_W  = 4;
  localparam int unsigned BA_W   = 2;

  localparam logic [CMD_W-1:0] CMD_NOP        = 4'b0111;
  localparam logic [CMD_W-1:0] CMD_P_CHARGE   = 4'b0010;
  localparam logic [CMD_W-1:0] CMD_AUTO_REF   = 4'b0001;
  localparam logic [CMD_W-1:0] CMD_M_REG_SET  = 4'b0000;
  localparam logic [CMD_W-1:0] CMD_ACTIVE     = 4'b0011;
  localparam logic [CMD_W-1:0] CMD_WRITE      = 4'b0100;
  localparam logic [CMD_W-1:0] CMD_READ       = 4'b0101;
  localparam logic [CMD_W-1:0] CMD_BURST_STOP = 4'b0110;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARBIT = 3'd1,
    AREF  = 3'd2,
    WRITE = 3'd3,
    READ  = 3'd4
  } arb_state_t;

endpackage

// File: rtl/sdram_arbit.sv
// SDRAM bus arbiter: after init, grants the bus to refresh, write or read by fixed
// priority and muxes the owner's command/bank/address onto the SDRAM pins.
module sdram_arbit
  import sdram_arbit_pkg::*;
#(
  parameter int unsigned DQ_W   = 16,
  parameter int unsigned ADDR_W = 11
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              init_end,
  input  logic [3:0]        init_cmd,
  input  logic [1:0]        init_ba,
  input  logic [ADDR_W-1:0] init_addr,
  input  logic              aref_req,
  input  logic              aref_end,
  input  logic [3:0]        aref_cmd,
  input  logic [1:0]        aref_ba,
  input  logic [ADDR_W-1:0] aref_addr,
  input  logic              wr_req,
  input  logic              wr_end,
  input  logic [3:0]        wr_cmd,
  input  logic [1:0]        wr_ba,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic              wr_sdram_en,
  input  logic [DQ_W-1:0]   wr_sdram_data,
  input  logic              rd_req,
  input  logic              rd_end,
  input  logic [3:0]        rd_cmd,
  input  logic [1:0]        rd_ba,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              aref_en,
  output logic              wr_en,
  output logic              rd_en,
  output logic              sdram_cke,
  output logic              sdram_cs_n,
  output logic              sdram_ras_n,
  output logic              sdram_cas_n,
  output logic              sdram_we_n,
  output logic [1:0]        sdram_ba,
  output logic [ADDR_W-1:0] sdram_addr,
  inout  wire  [DQ_W-1:0]   sdram_dq
);

  arb_state_t        state, state_nxt;
  logic [CMD_W-1:0]  cmd_sel;
  logic [BA_W-1:0]   ba_sel;
  logic [ADDR_W-1:0] addr_sel;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state   <= IDLE;
      aref_en <= 1'b0;
      wr_en   <= 1'b0;
      rd_en   <= 1'b0;
    end else begin
      state   <= state_nxt;
      aref_en <= (state_nxt == AREF);
      wr_en   <= (state_nxt == WRITE);
      rd_en   <= (state_nxt == READ);
    end
  end

  // Owner releases the bus only on its own end pulse; ARBIT always sits between grants.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (init_end) state_nxt = ARBIT;
      ARBIT: begin
        if (aref_req)      state_nxt = AREF;
        else if (wr_req)   state_nxt = WRITE;
        else if (rd_req)   state_nxt = READ;
      end
      AREF:    if (aref_end) state_nxt = ARBIT;
      WRITE:   if (wr_end)   state_nxt = ARBIT;
      READ:    if (rd_end)   state_nxt = ARBIT;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cmd_sel  = CMD_NOP;
    ba_sel   = 2'b11;
    addr_sel = '1;
    case (state)
      IDLE: begin
        cmd_sel  = init_cmd;
        ba_sel   = init_ba;
        addr_sel = init_addr;
      end
      AREF: begin
        cmd_sel  = aref_cmd;
        ba_sel   = aref_ba;
        addr_sel = aref_addr;
      end
      WRITE: begin
        cmd_sel  = wr_cmd;
        ba_sel   = wr_ba;
        addr_sel = wr_addr;
      end
      READ: begin
        cmd_sel  = rd_cmd;
        ba_sel   = rd_ba;
        addr_sel = rd_addr;
      end
      default: ;
    endcase
  end

  assign sdram_cke = 1'b1;
  assign {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = cmd_sel;
  assign sdram_ba   = ba_sel;
  assign sdram_addr = addr_sel;
  assign sdram_dq   = wr_sdram_en ? wr_sdram_data : {DQ_W{1'bz}};

endmodule

// File: doc/sdram_arbit.md
SDRAM_ARBIT -- requirements
Module: sdram_arbit

Interface
REQ-001 Parameter DQ_W, default 16: SDRAM data width.
REQ-002 Parameter ADDR_W, default 11: SDRAM address width.
REQ-003 Port sys_clk  in  1: 100 MHz system clock; all logic on its rising edge.
REQ-004 Port sys_rst_n  in  1: reset, asynchronous, active-low.
REQ-005 Port init_end  in  1: SDRAM initialisation complete, level.
REQ-006 Port init_cmd/init_ba/init_addr  in  4/2/ADDR_W: command, bank and address from the init sequencer.
REQ-007 Port aref_req  in  1: auto-refresh request, level, held until granted.
REQ-008 Port aref_end  in  1: one-cycle pulse, refresh sequence finished.
REQ-009 Port aref_cmd/aref_ba/aref_addr  in  4/2/ADDR_W: refresh command, bank and address.
REQ-010 Port wr_req, wr_end  in  1 each: write request (level) and write-done pulse.
REQ-011 Port wr_cmd/wr_ba/wr_addr  in  4/2/ADDR_W: write command, bank and address.
REQ-012 Port wr_sdram_en  in  1: write data drive enable.
REQ-013 Port wr_sdram_data  in  DQ_W: write data.
REQ-014 Port rd_req, rd_end  in  1 each: read request (level) and read-done pulse.
REQ-015 Port rd_cmd/rd_ba/rd_addr  in  4/2/ADDR_W: read command, bank and address.
REQ-016 Port aref_en, wr_en, rd_en  out  1 each: grant to the corresponding requester, registered.
REQ-017 Port sdram_cke  out  1: clock enable, constant 1.
REQ-018 Port sdram_cs_n/ras_n/cas_n/we_n  out  1 each: command pins, equal to {cs_n,ras_n,cas_n,we_n} = selected cmd.
REQ-019 Port sdram_ba/sdram_addr  out  2/ADDR_W: selected bank and address.
REQ-020 Port sdram_dq  inout  DQ_W: driven with wr_sdram_data when wr_sdram_en=1, otherwise high-Z.

Function
REQ-021 The state machine SHALL use the states IDLE, ARBIT, AREF, WRITE and READ.
REQ-022 IDLE SHALL move to ARBIT in the cycle after init_end=1 is sampled; otherwise it holds.
REQ-023 In ARBIT, fixed priority SHALL apply: aref_req beats wr_req, and wr_req beats rd_req. The winner's state is entered on the next edge; with no request, the state stays ARBIT.
REQ-024 AREF, WRITE and READ SHALL hold until their own *_end=1 is sampled, then return to ARBIT. Requests arriving meanwhile wait; there is no preemption.
REQ-025 Each grant SHALL be asserted as follows:
- aref_en=1 from the cycle the state becomes AREF through the cycle aref_end is sampled.
- aref_en clears on the edge that leaves AREF.
- wr_en and rd_en follow the same rule for WRITE and READ.
- At most one grant is high at any time.
REQ-026 The command, bank and address mux SHALL be combinational from the state:
- IDLE selects init_*.
- AREF selects aref_*, WRITE selects wr_*, READ selects rd_*.
- ARBIT drives NOP 4'b0111, ba=2'b11, addr all ones.
REQ-027 A request and the *_end of the current owner in the same cycle: the state SHALL return to ARBIT first, so the minimum gap between grants is one ARBIT cycle.
REQ-028 If init_end drops outside IDLE, the state SHALL be unaffected; only reset returns the machine to IDLE.
REQ-029 A *_end pulse seen in a state that does not own it SHALL be ignored.

Reset
REQ-030 On sys_rst_n=0 the block SHALL immediately force state=IDLE and aref_en=wr_en=rd_en=0. The outputs then follow init_*, and sdram_dq is high-Z.
REQ-031 Reset asserted mid-transaction SHALL abort the grant with no completion pulse required.

Structure
REQ-032 The command encodings (NOP, P_CHARGE, AUTO_REF, M_REG_SET, ACTIVE, WRITE, READ, BURST_STOP) and the state encodings SHALL live in the shared sdram package for reuse by the init, aref, write and read blocks.
REQ-033 The block SHALL be a single module with no sub-modules; the tri-state driver is inline.

Verification
REQ-034 Reset, then init_end=1 at cycle 10: state reaches ARBIT at cycle 11. Before that, outputs mirror init_cmd=0010; after, cmd=0111.
REQ-035 aref_req, wr_req and rd_req all raised together in ARBIT: aref_en is granted first. After aref_end, one ARBIT cycle follows, then wr_en. After wr_end, rd_en is granted.
REQ-036 In WRITE with wr_cmd=0100, ba=2'b01, addr=11'h012 and wr_sdram_en=1, data=16'hA5A5: the pins show cs/ras/cas/we = 0,1,0,0 and sdram_dq=16'hA5A5. With wr_sdram_en=0, sdram_dq is Z.
REQ-037 aref_req raised during a 20-cycle READ: rd_en stays high until rd_end, and aref_en rises 2 cycles after rd_end.
REQ-038 sys_rst_n pulled low mid-WRITE: wr_en falls asynchronously and state=IDLE. After release, no grant is issued until init_end=1.
